dma_cfg_regs: RTL and testbench

DMA_CFG_REGS -- requirements
Module: dma_cfg_regs

---
 rtl/dma_cfg_regs.sv | 226 ++++++++++++++++++++++
 tb/tb_dma_cfg_regs.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_cfg_regs.sv
// rtl/dma_cfg_regs.sv - AHB-Lite descriptor register block with launch/queue control for a DMA engine
//
// Purpose: holds a programmable DMA descriptor (SRC/DST/SIZE/LEN), launches it to
// the engine on a legal START, queues one further descriptor while the engine is
// busy, and reports completion/error status with a level interrupt.
//
// Ports:
//   HCLK, HRESETn                    clock, asynchronous active-low reset
//   HSEL..HREADY                     AHB-Lite slave request inputs
//   HREADYOUT, HRESP, HRDATA         AHB-Lite slave response (zero wait, OKAY only)
//   DMAsrc, DMAdst, DMAsize, DMAlen  active descriptor to the engine
//   DMAstart                         one-cycle launch pulse
//   DMAdone                          one-cycle completion pulse from the engine
//   DMA_IRQ                          level interrupt, IE & (DONE | ERR)
module dma_cfg_regs #(
   parameter int SLV_ADDR_W = 8
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [SLV_ADDR_W-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [31:0]           HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic [1:0]            HRESP,
   output logic [31:0]           HRDATA,
   output logic [31:0]           DMAsrc,
   output logic [31:0]           DMAdst,
   output logic [2:0]            DMAsize,
   output logic [31:0]           DMAlen,
   output logic                  DMAstart,
   input  logic                  DMAdone,
   output logic                  DMA_IRQ
);

   typedef enum logic [1:0] {IDLE, ACTIVE, ACTIVE_PEND} state_e;

   state_e      state_q, state_d;
   logic [3:0]  addr_q, addr_d;
   logic        wr_q, wr_d, valid_q, valid_d;
   logic [31:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
   logic [2:0]  size_q, size_d;
   logic        ie_q, ie_d, done_q, done_d, err_q, err_d;
   logic [31:0] act_src_q, act_src_d, act_dst_q, act_dst_d, act_len_q, act_len_d;
   logic [2:0]  act_size_q, act_size_d;
   logic [31:0] pnd_src_q, pnd_src_d, pnd_dst_q, pnd_dst_d, pnd_len_q, pnd_len_d;
   logic [2:0]  pnd_size_q, pnd_size_d;
   logic        dmastart_q, dmastart_d, irq_q, irq_d;
   logic        wr_en, start_req, start_ok;
   logic [31:0] rdata;
   logic        unused_inputs;

   assign unused_inputs = ^{HSIZE, HTRANS[0], HADDR[1:0], HADDR[SLV_ADDR_W-1:6]};

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wr_d       = wr_q;
      valid_d    = valid_q;
      src_d      = src_q;
      dst_d      = dst_q;
      size_d     = size_q;
      len_d      = len_q;
      ie_d       = ie_q;
      done_d     = done_q;
      err_d      = err_q;
      act_src_d  = act_src_q;
      act_dst_d  = act_dst_q;
      act_size_d = act_size_q;
      act_len_d  = act_len_q;
      pnd_src_d  = pnd_src_q;
      pnd_dst_d  = pnd_dst_q;
      pnd_size_d = pnd_size_q;
      pnd_len_d  = pnd_len_q;
      dmastart_d = 1'b0;

      // Address phase capture; an idle/unselected beat closes the data phase.
      if (HSEL && HTRANS[1] && HREADY) begin
         addr_d  = HADDR[5:2];
         wr_d    = HWRITE;
         valid_d = 1'b1;
      end else if (HREADY) begin
         valid_d = 1'b0;
      end

      wr_en = valid_q && wr_q;
      if (wr_en) begin
         case (addr_q)
            4'h0: src_d  = HWDATA;
            4'h1: dst_d  = HWDATA;
            4'h2: size_d = HWDATA[2:0];
            4'h3: len_d  = HWDATA;
            4'h4: ie_d   = HWDATA[1];
            4'h5: begin
               // Clears first; sets below override them in the same cycle.
               if (HWDATA[1]) done_d = 1'b0;
               if (HWDATA[3]) err_d  = 1'b0;
            end
            default: ;
         endcase
      end

      start_req = wr_en && (addr_q == 4'h4) && HWDATA[0];
      start_ok  = start_req && (len_q != 32'd0) && (size_q[1:0] != 2'b11);
      if (start_req && !start_ok) err_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (start_ok) begin
               {act_src_d, act_dst_d, act_size_d, act_len_d} = {src_q, dst_q, size_q, len_q};
               dmastart_d = 1'b1;
               state_d    = ACTIVE;
            end
         end
         ACTIVE: begin
            if (DMAdone) done_d = 1'b1;
            if (start_ok && DMAdone) begin
               // Engine just finished, so the new descriptor bypasses the pending slot.
               {act_src_d, act_dst_d, act_size_d, act_len_d} = {src_q, dst_q, size_q, len_q};
               dmastart_d = 1'b1;
            end else if (start_ok) begin
               {pnd_src_d, pnd_dst_d, pnd_size_d, pnd_len_d} = {src_q, dst_q, size_q, len_q};
               state_d = ACTIVE_PEND;
            end else if (DMAdone) begin
               state_d = IDLE;
            end
         end
         ACTIVE_PEND: begin
            if (DMAdone) begin
               done_d = 1'b1;
               {act_src_d, act_dst_d, act_size_d, act_len_d} = {pnd_src_q, pnd_dst_q, pnd_size_q, pnd_len_q};
               dmastart_d = 1'b1;
               if (start_ok) begin
                  // Pending slot is being drained this cycle, so it can take the new one.
                  {pnd_src_d, pnd_dst_d, pnd_size_d, pnd_len_d} = {src_q, dst_q, size_q, len_q};
               end else begin
                  state_d = ACTIVE;
               end
            end else if (start_ok) begin
               err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      irq_d = ie_d && (done_d || err_d);
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= IDLE;
         addr_q     <= 4'h0;
         wr_q       <= 1'b0;
         valid_q    <= 1'b0;
         src_q      <= 32'h0;
         dst_q      <= 32'h0;
         size_q     <= 3'h0;
         len_q      <= 32'h0;
         ie_q       <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         act_src_q  <= 32'h0;
         act_dst_q  <= 32'h0;
         act_size_q <= 3'h0;
         act_len_q  <= 32'h0;
         pnd_src_q  <= 32'h0;
         pnd_dst_q  <= 32'h0;
         pnd_size_q <= 3'h0;
         pnd_len_q  <= 32'h0;
         dmastart_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wr_q       <= wr_d;
         valid_q    <= valid_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         size_q     <= size_d;
         len_q      <= len_d;
         ie_q       <= ie_d;
         done_q     <= done_d;
         err_q      <= err_d;
         act_src_q  <= act_src_d;
         act_dst_q  <= act_dst_d;
         act_size_q <= act_size_d;
         act_len_q  <= act_len_d;
         pnd_src_q  <= pnd_src_d;
         pnd_dst_q  <= pnd_dst_d;
         pnd_size_q <= pnd_size_d;
         pnd_len_q  <= pnd_len_d;
         dmastart_q <= dmastart_d;
         irq_q      <= irq_d;
      end
   end

   // Read data is only driven during a read data phase; START always reads back 0.
   always_comb begin
      rdata = 32'h0;
      if (valid_q && !wr_q) begin
         case (addr_q)
            4'h0: rdata = src_q;
            4'h1: rdata = dst_q;
            4'h2: rdata = {29'h0, size_q};
            4'h3: rdata = len_q;
            4'h4: rdata = {30'h0, ie_q, 1'b0};
            4'h5: rdata = {28'h0, err_q, (state_q == ACTIVE_PEND), done_q, (state_q != IDLE)};
            default: rdata = 32'h0;
         endcase
      end
   end

   assign HRDATA    = rdata;
   assign HREADYOUT = 1'b1;
   assign HRESP     = 2'b00;
   assign DMAsrc    = act_src_q;
   assign DMAdst    = act_dst_q;
   assign DMAsize   = act_size_q;
   assign DMAlen    = act_len_q;
   assign DMAstart  = dmastart_q;
   assign DMA_IRQ   = irq_q;

endmodule

// File: tb/tb_dma_cfg_regs.sv
// tb/tb_dma_cfg_regs.sv - self-checking bench for dma_cfg_regs
module tb_dma_cfg_regs;

   localparam logic [3:0] R_SRC = 4'h0, R_DST = 4'h1, R_SIZE = 4'h2, R_LEN = 4'h3,
                          R_CTRL = 4'h4, R_STAT = 4'h5;

   typedef struct packed {
      logic [31:0] src;
      logic [31:0] dst;
      logic [2:0]  size;
      logic [31:0] len;
   } desc_t;

   logic        HCLK = 1'b0;
   logic        HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, DMAstart, DMAdone, DMA_IRQ;
   logic [7:0]  HADDR;
   logic [1:0]  HTRANS, HRESP;
   logic [2:0]  HSIZE, DMAsize;
   logic [31:0] HWDATA, HRDATA, DMAsrc, DMAdst, DMAlen;

   int n_checks = 0;
   int n_errors = 0;
   int start_cnt = 0;

   // Reference model state
   desc_t       m_regs, m_act, m_pend;
   logic        m_ie, m_done, m_err, m_busy, m_haspend;
   int          m_starts;

   dma_cfg_regs #(.SLV_ADDR_W(8)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
      .DMAsrc(DMAsrc), .DMAdst(DMAdst), .DMAsize(DMAsize), .DMAlen(DMAlen),
      .DMAstart(DMAstart), .DMAdone(DMAdone), .DMA_IRQ(DMA_IRQ)
   );

   always #5 HCLK = ~HCLK;

   always @(negedge HCLK) if (DMAstart === 1'b1) start_cnt++;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One AHB transfer; returns #1 after the edge that ends the data phase.
   task automatic bus(input logic wr, input logic [3:0] idx, input logic [31:0] wdata,
                      input logic dn, output logic [31:0] rdata);
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HWRITE = wr;
      HSIZE  = 3'b010;
      HADDR  = {2'($urandom_range(0, 3)), idx, 2'b00};
      @(posedge HCLK); #1;
      HSEL    = 1'b0;
      HTRANS  = 2'b00;
      HWRITE  = 1'b0;
      HWDATA  = wr ? wdata : 32'h0;
      DMAdone = dn;
      rdata   = HRDATA;
      @(posedge HCLK); #1;
      DMAdone = 1'b0;
   endtask

   task automatic pulse_done();
      DMAdone = 1'b1;
      @(posedge HCLK); #1;
      DMAdone = 1'b0;
   endtask

   // One cycle of the programmer's-view rules: clears, completion, then the START request.
   task automatic m_step(input logic start, input logic dn, input logic cd, input logic ce,
                         output logic launch);
      launch = 1'b0;
      if (cd) m_done = 1'b0;
      if (ce) m_err  = 1'b0;
      if (dn && m_busy) begin
         m_done = 1'b1;
         if (m_haspend) begin
            m_act = m_pend; m_haspend = 1'b0; launch = 1'b1;
         end else begin
            m_busy = 1'b0;
         end
      end
      if (start) begin
         if (m_regs.len == 0 || m_regs.size[1:0] == 2'b11) m_err = 1'b1;
         else if (!m_busy) begin m_act = m_regs; m_busy = 1'b1; launch = 1'b1; end
         else if (!m_haspend) begin m_pend = m_regs; m_haspend = 1'b1; end
         else m_err = 1'b1;
      end
      if (launch) m_starts++;
   endtask

   function automatic logic [31:0] m_read(input logic [3:0] idx);
      case (idx)
         R_SRC:  return m_regs.src;
         R_DST:  return m_regs.dst;
         R_SIZE: return {29'h0, m_regs.size};
         R_LEN:  return m_regs.len;
         R_CTRL: return {30'h0, m_ie, 1'b0};
         R_STAT: return {28'h0, m_err, m_haspend, m_done, m_busy};
         default: return 32'h0;
      endcase
   endfunction

   initial begin
      logic [31:0] rd, wd, exp_rd;
      logic [3:0]  idx;
      logic        dn, launch;
      int          s0, op;

      HRESETn = 1'b0; HSEL = 1'b0; HADDR = 8'h0; HTRANS = 2'b00; HWRITE = 1'b0;
      HSIZE = 3'b0; HWDATA = 32'h0; HREADY = 1'b1; DMAdone = 1'b0;
      repeat (3) @(posedge HCLK);
      #1;
      chk("rst_hrdata", HRDATA, 32'h0);
      chk("rst_start", 32'(DMAstart), 32'h0);
      chk("rst_irq", 32'(DMA_IRQ), 32'h0);
      chk("rst_hreadyout", 32'(HREADYOUT), 32'h1);
      chk("rst_hresp", 32'(HRESP), 32'h0);
      chk("rst_dmasrc", DMAsrc, 32'h0);
      HRESETn = 1'b1;
      @(posedge HCLK); #1;
      bus(0, R_STAT, 0, 0, rd); chk("rst_status", rd, 32'h0);

      // Basic launch, completion, interrupt and W1C clear
      s0 = start_cnt;
      bus(1, R_SRC, 32'h2000_0000, 0, rd);
      bus(1, R_DST, 32'h4000_0000, 0, rd);
      bus(1, R_SIZE, 32'd2, 0, rd);
      bus(1, R_LEN, 32'd16, 0, rd);
      bus(1, R_CTRL, 32'h3, 0, rd);
      chk("t1_start", 32'(DMAstart), 32'h1);
      chk("t1_src", DMAsrc, 32'h2000_0000);
      chk("t1_dst", DMAdst, 32'h4000_0000);
      chk("t1_size", 32'(DMAsize), 32'd2);
      chk("t1_len", DMAlen, 32'd16);
      @(posedge HCLK); #1;
      chk("t1_start_width", 32'(DMAstart), 32'h0);
      bus(0, R_STAT, 0, 0, rd); chk("t1_status_busy", rd, 32'h1);
      bus(0, R_CTRL, 0, 0, rd); chk("t1_ctrl_read", rd, 32'h2);
      chk("t1_start_count", 32'(start_cnt - s0), 32'd1);
      pulse_done();
      bus(0, R_STAT, 0, 0, rd); chk("t1_status_done", rd, 32'h2);
      chk("t1_irq_set", 32'(DMA_IRQ), 32'h1);
      bus(1, R_STAT, 32'h2, 0, rd);
      chk("t1_irq_clr", 32'(DMA_IRQ), 32'h0);
      bus(0, R_STAT, 0, 0, rd); chk("t1_status_clr", rd, 32'h0);

      // Queue while busy, then launch the queued descriptor on completion
      bus(1, R_CTRL, 32'h3, 0, rd);
      bus(1, R_SRC, 32'h100, 0, rd);
      bus(1, R_CTRL, 32'h3, 0, rd);
      chk("t2_no_start_queued", 32'(DMAstart), 32'h0);
      bus(0, R_STAT, 0, 0, rd); chk("t2_status_pend", rd, 32'h5);
      chk("t2_active_held", DMAsrc, 32'h2000_0000);
      pulse_done();
      chk("t2_start_from_pend", 32'(DMAstart), 32'h1);
      chk("t2_src_from_pend", DMAsrc, 32'h100);
      bus(0, R_STAT, 0, 0, rd); chk("t2_status", rd, 32'h3);

      // Third START while a descriptor is pending is rejected
      bus(1, R_STAT, 32'h2, 0, rd);
      bus(1, R_SRC, 32'h200, 0, rd);
      bus(1, R_CTRL, 32'h3, 0, rd);
      bus(1, R_CTRL, 32'h3, 0, rd);
      bus(0, R_STAT, 0, 0, rd); chk("t3_status_err", rd, 32'hD);
      s0 = start_cnt;
      pulse_done();
      pulse_done();
      @(posedge HCLK); #1;
      chk("t3_one_start", 32'(start_cnt - s0), 32'd1);
      chk("t3_src", DMAsrc, 32'h200);
      bus(0, R_STAT, 0, 0, rd); chk("t3_status_idle", rd, 32'hA);
      bus(1, R_STAT, 32'hA, 0, rd);
      bus(0, R_STAT, 0, 0, rd); chk("t3_status_clr", rd, 32'h0);

      // Illegal STARTs: LEN==0, then SIZE==3
      s0 = start_cnt;
      bus(1, R_LEN, 32'd0, 0, rd);
      bus(1, R_CTRL, 32'h1, 0, rd);
      chk("t4_len0_nostart", 32'(DMAstart), 32'h0);
      bus(0, R_STAT, 0, 0, rd); chk("t4_len0_status", rd, 32'h8);
      bus(1, R_STAT, 32'h8, 0, rd);
      bus(1, R_LEN, 32'd4, 0, rd);
      bus(1, R_SIZE, 32'd3, 0, rd);
      bus(1, R_CTRL, 32'h1, 0, rd);
      bus(0, R_STAT, 0, 0, rd); chk("t4_size3_status", rd, 32'h8);
      chk("t4_no_starts", 32'(start_cnt - s0), 32'd0);
      bus(1, R_STAT, 32'h8, 0, rd);
      bus(1, R_SIZE, 32'd2, 0, rd);

      // START coincident with DMAdone while ACTIVE
      bus(1, R_CTRL, 32'h3, 0, rd);
      chk("t5_first_start", 32'(DMAstart), 32'h1);
      bus(1, R_SRC, 32'h300, 0, rd);
      bus(1, R_CTRL, 32'h3, 1, rd);
      chk("t5_direct_start", 32'(DMAstart), 32'h1);
      chk("t5_direct_src", DMAsrc, 32'h300);
      chk("t5_direct_len", DMAlen, 32'd4);
      bus(0, R_STAT, 0, 0, rd); chk("t5_status", rd, 32'h3);

      // DONE set wins over a W1C clear in the same cycle; DMAdone ignored while IDLE
      bus(1, R_STAT, 32'h2, 1, rd);
      bus(0, R_STAT, 0, 0, rd); chk("t6_set_priority", rd, 32'h2);
      bus(1, R_STAT, 32'h2, 0, rd);
      pulse_done();
      bus(0, R_STAT, 0, 0, rd); chk("t6_idle_done_ignored", rd, 32'h0);

      // Reset during ACTIVE_PEND
      bus(1, R_CTRL, 32'h3, 0, rd);
      bus(1, R_CTRL, 32'h3, 0, rd);
      bus(0, R_STAT, 0, 0, rd); chk("t7_pend_before_rst", rd, 32'h5);
      s0 = start_cnt;
      HRESETn = 1'b0;
      #1;
      chk("t7_rst_src", DMAsrc, 32'h0);
      chk("t7_rst_dst", DMAdst, 32'h0);
      chk("t7_rst_size", 32'(DMAsize), 32'h0);
      chk("t7_rst_len", DMAlen, 32'h0);
      chk("t7_rst_start", 32'(DMAstart), 32'h0);
      chk("t7_rst_irq", 32'(DMA_IRQ), 32'h0);
      chk("t7_rst_hrdata", HRDATA, 32'h0);
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      pulse_done();
      repeat (3) @(posedge HCLK);
      #1;
      chk("t7_no_start_after", 32'(start_cnt - s0), 32'd0);
      bus(0, R_STAT, 0, 0, rd); chk("t7_status", rd, 32'h0);
      bus(0, R_SRC, 0, 0, rd); chk("t7_src_reg", rd, 32'h0);

      // Randomized traffic against the reference model (all state is zero after reset)
      m_regs = '0; m_act = '0; m_pend = '0;
      m_ie = 1'b0; m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_haspend = 1'b0;
      m_starts = 0;
      s0 = start_cnt;
      for (int i = 0; i < 400; i++) begin
         op = $urandom_range(0, 4);
         dn = ($urandom_range(0, 3) == 0);
         wd = $urandom;
         case (op)
            0: begin
               idx = 4'($urandom_range(0, 3));
               if (idx == R_LEN && $urandom_range(0, 3) == 0) wd = 32'h0;
               bus(1, idx, wd, dn, rd);
               m_step(1'b0, dn, 1'b0, 1'b0, launch);
               case (idx)
                  R_SRC:  m_regs.src  = wd;
                  R_DST:  m_regs.dst  = wd;
                  R_SIZE: m_regs.size = wd[2:0];
                  default: m_regs.len = wd;
               endcase
            end
            1: begin
               wd = 32'($urandom_range(0, 3));
               bus(1, R_CTRL, wd, dn, rd);
               m_ie = wd[1];
               m_step(wd[0], dn, 1'b0, 1'b0, launch);
            end
            2: begin
               bus(1, R_STAT, wd, dn, rd);
               m_step(1'b0, dn, wd[1], wd[3], launch);
            end
            3: begin
               pulse_done();
               m_step(1'b0, 1'b1, 1'b0, 1'b0, launch);
            end
            default: begin
               idx = 4'($urandom_range(0, 15));
               exp_rd = m_read(idx);
               bus(0, idx, 0, 1'b0, rd);
               chk($sformatf("rnd%0d_read_%0h", i, idx), rd, exp_rd);
               m_step(1'b0, 1'b0, 1'b0, 1'b0, launch);
            end
         endcase
         chk($sformatf("rnd%0d_start", i), 32'(DMAstart), 32'(launch));
         chk($sformatf("rnd%0d_src", i), DMAsrc, m_act.src);
         chk($sformatf("rnd%0d_dst", i), DMAdst, m_act.dst);
         chk($sformatf("rnd%0d_size", i), 32'(DMAsize), 32'(m_act.size));
         chk($sformatf("rnd%0d_len", i), DMAlen, m_act.len);
         chk($sformatf("rnd%0d_irq", i), 32'(DMA_IRQ), 32'(m_ie & (m_done | m_err)));
      end
      @(posedge HCLK); #1;
      chk("rnd_total_starts", 32'(start_cnt - s0), 32'(m_starts));
      bus(0, R_STAT, 0, 0, rd); chk("rnd_final_status", rd, m_read(R_STAT));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
